// File: rtl/bram_result_drain_if.sv
// Signal bundle for bram_result_drain: host control, BRAM read port and result stream.
// The block under test takes the slave side; the host/BRAM/consumer side takes master.
interface bram_result_drain_if #(
    parameter int BRAM_DWIDTH   = 40,
    parameter int BRAM_AWIDTH   = 9,
    parameter int RESULT_DWIDTH = 9
);
    logic                     start;
    logic [BRAM_AWIDTH-1:0]   start_addr;
    logic [BRAM_AWIDTH:0]     num_words;
    logic                     busy;
    logic                     done;
    logic [BRAM_AWIDTH-1:0]   bram_addr;
    logic                     bram_re;
    logic [BRAM_DWIDTH-1:0]   bram_data;
    logic [RESULT_DWIDTH-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport master (
        output start, start_addr, num_words, bram_data, out_ready,
        input  busy, done, bram_addr, bram_re, out_data, out_valid, out_last
    );

    modport slave (
        input  start, start_addr, num_words, bram_data, out_ready,
        output busy, done, bram_addr, bram_re, out_data, out_valid, out_last
    );
endinterface

// File: rtl/bram_result_drain.sv
// Sweeps a BRAM address range, extracts the result field of each word and streams it
// out over valid/ready, absorbing the one-cycle BRAM latency with a small FIFO.
module bram_result_drain #(
    parameter int BRAM_DWIDTH   = 40,
    parameter int BRAM_AWIDTH   = 9,
    parameter int RESULT_DWIDTH = 9,
    parameter int RESULT_LSB    = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input logic                clk,
    input logic                reset,
    bram_result_drain_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int NW_W  = BRAM_AWIDTH + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                   state_q;
    logic [BRAM_AWIDTH-1:0]   addr_q;
    logic                     re_q;
    logic                     re_last_q;
    logic                     rd_valid_q;
    logic                     rd_last_q;
    logic [NW_W-1:0]          issue_left_q;
    logic                     busy_q;
    logic                     done_q;

    logic [RESULT_DWIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic                     fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]         fifo_count_q;

    logic                     out_valid_s;
    logic                     pop_s;
    logic                     push_s;
    logic                     head_last_s;
    logic                     issue_d;
    logic [OCC_W-1:0]         occupancy_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    // Handshake decode and issue decision; occupancy counts reads still in flight
    always_comb begin
        out_valid_s = (fifo_count_q != CNT_W'(0));
        pop_s       = out_valid_s && bus.out_ready;
        push_s      = rd_valid_q;
        head_last_s = fifo_last_q[rd_ptr_q];
        occupancy_s = OCC_W'(fifo_count_q) + OCC_W'(re_q) + OCC_W'(rd_valid_q) - OCC_W'(pop_s);
        issue_d     = (state_q == S_RUN) && (issue_left_q != NW_W'(0))
                      && (occupancy_s < OCC_W'(FIFO_DEPTH));
    end

    // Control FSM, read-address generator and BRAM latency pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= BRAM_AWIDTH'(0);
            re_q         <= 1'b0;
            re_last_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            issue_left_q <= NW_W'(0);
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            rd_valid_q <= re_q;
            rd_last_q  <= re_last_q;
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        addr_q <= bus.start_addr;
                        busy_q <= 1'b1;
                        if (bus.num_words == NW_W'(0)) begin
                            state_q      <= S_FINISH;
                            done_q       <= 1'b1;
                            re_q         <= 1'b0;
                            re_last_q    <= 1'b0;
                            issue_left_q <= NW_W'(0);
                        end else begin
                            // The first read goes out immediately, so it is already accounted for
                            state_q      <= S_RUN;
                            re_q         <= 1'b1;
                            re_last_q    <= (bus.num_words == NW_W'(1));
                            issue_left_q <= bus.num_words - NW_W'(1);
                        end
                    end else begin
                        re_q      <= 1'b0;
                        re_last_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    re_q      <= issue_d;
                    re_last_q <= issue_d && (issue_left_q == NW_W'(1));
                    if (issue_d) begin
                        addr_q       <= addr_q + BRAM_AWIDTH'(1);
                        issue_left_q <= issue_left_q - NW_W'(1);
                    end else begin
                        addr_q       <= addr_q;
                        issue_left_q <= issue_left_q;
                    end
                    if (pop_s && head_last_s) begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                        done_q  <= 1'b0;
                    end
                end
                S_FINISH: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    re_q      <= 1'b0;
                    re_last_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    re_q      <= 1'b0;
                    re_last_q <= 1'b0;
                end
            endcase
        end
    end

    // Output FIFO: push on returning read data, pop on stream transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= PTR_W'(0);
            rd_ptr_q     <= PTR_W'(0);
            fifo_count_q <= CNT_W'(0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= RESULT_DWIDTH'(0);
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                fifo_data_q[wr_ptr_q] <= bus.bram_data[RESULT_LSB +: RESULT_DWIDTH];
                fifo_last_q[wr_ptr_q] <= rd_last_q;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_re   = re_q;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_valid_s ? fifo_data_q[rd_ptr_q] : RESULT_DWIDTH'(0);
    assign bus.out_last  = out_valid_s && head_last_s;
endmodule

// File: tb/tb_bram_result_drain.sv
// Directed and randomized bench for bram_result_drain with a BRAM model and a
// queue-based reference of the expected result stream.
`timescale 1ns/1ps
module tb_bram_result_drain;
    localparam int DW    = 40;
    localparam int AW    = 9;
    localparam int RW    = 9;
    localparam int LSB   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bram_result_drain_if #(.BRAM_DWIDTH(DW), .BRAM_AWIDTH(AW), .RESULT_DWIDTH(RW)) bus ();

    bram_result_drain #(
        .BRAM_DWIDTH(DW), .BRAM_AWIDTH(AW), .RESULT_DWIDTH(RW),
        .RESULT_LSB(LSB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int re_cnt = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    logic [DW-1:0] mem [512];
    logic [RW:0]   got_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // BRAM model: one-cycle read latency, garbage when not reading
    always @(posedge clk) begin
        if (bus.bram_re) bus.bram_data <= mem[bus.bram_addr];
        else             bus.bram_data <= DW'({$urandom(), $urandom()});
    end

    // Stream monitor and per-cycle invariants
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.bram_re)   re_cnt++;
            if (bus.done)      done_cnt++;
            if (bus.out_valid) valid_cnt++;
            if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.out_data});
            check("fifo_bound", 64'(dut.fifo_count_q <= 3'(DEPTH)), 64'(1));
            if (dut.fifo_count_q == 3'(DEPTH)) check("re_when_full", 64'(bus.bram_re), 64'(0));
            if (!bus.out_valid) check("idle_data", 64'({bus.out_last, bus.out_data}), 64'(0));
        end
    end

    task automatic run_drain(input logic [AW-1:0] a, input int n, input bit rnd, input int restart_cyc);
        logic [RW:0]    exp_q [$];
        logic [AW-1:0]  ad;
        logic [RW-1:0]  exp_data;
        bit             exp_valid;
        int cyc;
        bit fin;
        int re0;
        int dn0;
        for (int i = 0; i < n; i++) begin
            ad = a + AW'(i);
            exp_q.push_back({(i == n - 1), mem[ad][LSB +: RW]});
        end
        got_q.delete();
        re0 = re_cnt;
        dn0 = done_cnt;
        bus.start      = 1'b1;
        bus.start_addr = a;
        bus.num_words  = 10'(n);
        bus.out_ready  = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        fin = 1'b0;
        while (!fin && cyc < 8 * n + 40) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == restart_cyc) begin
                bus.start      = 1'b1;
                bus.start_addr = a + 9'd77;
                bus.num_words  = 10'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (!rnd) begin
                exp_valid = (cyc >= 3) && (cyc <= n + 2);
                ad        = a + AW'(cyc - 3);
                exp_data  = exp_valid ? mem[ad][LSB +: RW] : RW'(0);
                check("re", 64'(bus.bram_re), 64'((cyc >= 1) && (cyc <= n)));
                if (cyc <= n) check("addr", 64'(bus.bram_addr), 64'(AW'(a + AW'(cyc - 1))));
                check("valid", 64'(bus.out_valid), 64'(exp_valid));
                check("data", 64'(bus.out_data), 64'(exp_data));
                check("last", 64'(bus.out_last), 64'(cyc == n + 2));
                check("done", 64'(bus.done), 64'(cyc == n + 3));
                check("busy", 64'(bus.busy), 64'(cyc <= n + 3));
            end
            if (bus.done) fin = 1'b1;
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        check("done_seen", 64'(fin), 64'(1));
        check("idle_after", 64'(bus.busy), 64'(0));
        check("n_words", 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) check("word", 64'(got_q[i]), 64'(exp_q[i]));
        check("re_count", 64'(re_cnt - re0), 64'(n));
        check("done_count", 64'(done_cnt - dn0), 64'(1));
    endtask

    initial begin
        int re0;
        int dn0;
        int v0;
        for (int i = 0; i < 512; i++) mem[i] = DW'({$urandom(), $urandom()});
        for (int i = 0; i < 4; i++) mem[i] = DW'({RW'(i + 1), 16'b0});

        reset = 1'b1;
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.num_words = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_re", 64'(bus.bram_re), 64'(0));
        check("rst_addr", 64'(bus.bram_addr), 64'(0));
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_data", 64'(bus.out_data), 64'(0));
        check("rst_last", 64'(bus.out_last), 64'(0));
        reset = 1'b0;
        tick();

        // Basic drain with known contents
        run_drain(9'd0, 4, 1'b0, -1);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("basic_val", 64'(got_q[i][RW-1:0]), 64'(i + 1));

        // Wrap-around
        run_drain(9'd510, 4, 1'b0, -1);

        // Start while busy is ignored
        run_drain(9'd100, 10, 1'b0, 4);

        // Back-pressure, then longer random drains
        run_drain(9'($urandom_range(0, 511)), 8, 1'b1, -1);
        for (int k = 0; k < 6; k++) run_drain(9'($urandom_range(0, 511)), $urandom_range(1, 40), 1'b1, -1);

        // Zero length
        re0 = re_cnt;
        v0  = valid_cnt;
        bus.start = 1'b1;
        bus.start_addr = 9'd33;
        bus.num_words = 10'd0;
        tick();
        bus.start = 1'b0;
        check("zero_done", 64'(bus.done), 64'(1));
        check("zero_busy", 64'(bus.busy), 64'(1));
        tick();
        check("zero_done_end", 64'(bus.done), 64'(0));
        check("zero_busy_end", 64'(bus.busy), 64'(0));
        repeat (5) tick();
        check("zero_no_re", 64'(re_cnt - re0), 64'(0));
        check("zero_no_valid", 64'(valid_cnt - v0), 64'(0));

        // Reset in cycle 6 of a 16-word drain
        dn0 = done_cnt;
        bus.start = 1'b1;
        bus.start_addr = 9'd200;
        bus.num_words = 10'd16;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_busy", 64'(bus.busy), 64'(0));
        check("mid_done", 64'(bus.done), 64'(0));
        check("mid_re", 64'(bus.bram_re), 64'(0));
        check("mid_addr", 64'(bus.bram_addr), 64'(0));
        check("mid_valid", 64'(bus.out_valid), 64'(0));
        check("mid_data", 64'(bus.out_data), 64'(0));
        check("mid_last", 64'(bus.out_last), 64'(0));
        re0 = re_cnt;
        repeat (20) tick();
        check("mid_no_re", 64'(re_cnt - re0), 64'(0));
        check("mid_no_done", 64'(done_cnt - dn0), 64'(0));
        run_drain(9'd300, 6, 1'b0, -1);

        // Start coinciding with reset is ignored
        reset = 1'b1;
        bus.start = 1'b1;
        bus.start_addr = 9'd5;
        bus.num_words = 10'd5;
        tick();
        reset = 1'b0;
        bus.start = 1'b0;
        check("rststart_busy", 64'(bus.busy), 64'(0));
        check("rststart_re", 64'(bus.bram_re), 64'(0));
        tick();
        check("rststart_re2", 64'(bus.bram_re), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_result_drain.md
# bram_result_drain

Reads computed result words back out of the output BRAM after a compute pass and streams the result field to the host side over a valid/ready interface. It is the read-side counterpart of the compute controller that writes results as `{out, 16'b0}`. The block sweeps a contiguous address range starting at a programmable address. It absorbs the BRAM read latency with a small FIFO so that it can sustain one word per cycle under back-pressure.

## Interface
- `BRAM_DWIDTH`, default 40: BRAM data width.
- `BRAM_AWIDTH`, default 9: BRAM address width. Addresses wrap modulo 2^BRAM_AWIDTH.
- `RESULT_DWIDTH`, default 9: width of the result field (compute width + 1).
- `RESULT_LSB`, default 16: bit position of the result field's LSB inside the BRAM word.
- `FIFO_DEPTH`, default 4: depth of the output FIFO. Must be ≥ 3 for full throughput.
- `clk`, input, 1: clock. All logic is on the rising edge.
- `reset`, input, 1: reset. Synchronous, active-high.
- `start`, input, 1: single-cycle request. Sampled only in IDLE.
- `start_addr`, input, BRAM_AWIDTH: first BRAM address to read. Captured on an accepted start.
- `num_words`, input, BRAM_AWIDTH+1: number of words to drain (0..1023). Captured on an accepted start.
- `busy`, output, 1: high from the cycle after an accepted start until the cycle in which `done` is high, inclusive.
- `done`, output, 1: one-cycle pulse at the end of a drain.
- `bram_addr`, output, BRAM_AWIDTH: registered read address.
- `bram_re`, output, 1: registered read enable.
- `bram_data`, input, BRAM_DWIDTH: read data. Valid exactly one cycle after `bram_re`.
- `out_data`, output, RESULT_DWIDTH: equals `bram_data[RESULT_LSB +: RESULT_DWIDTH]` of the FIFO head entry. Forced to 0 when `out_valid` is 0.
- `out_valid`, output, 1: the FIFO is non-empty.
- `out_ready`, input, 1: consumer accepts. A transfer occurs when `out_valid && out_ready`.
- `out_last`, output, 1: the head entry is the final word of the drain. Qualified by `out_valid`.

## Operation
- **States:** IDLE, RUN, FINISH.
  - IDLE: on `start`, capture `start_addr` and `num_words`, then go to RUN. If `num_words==0`, go directly to FINISH instead.
  - RUN: stays in RUN until all `num_words` reads are issued and the last word has been transferred on the output.
  - FINISH: lasts exactly one cycle with `done=1`, then returns to IDLE.
- **Issue counter:** `issue_left` is loaded with `num_words` on start. Each asserted `bram_re` decrements it.
  - `bram_addr` starts at `start_addr` and increments by 1 after each issued read, wrapping from 511 to 0.
  - After the final read, `bram_addr` holds its last value and `bram_re` returns to 0.
- **Outstanding reads:** `outstanding` counts reads issued but not yet written to the FIFO. There are at most 2 (one in the `bram_re` register, one in the BRAM stage).
- **Issue rule:** the next-cycle `bram_re` is 1 when all of the following hold:
  - state is RUN,
  - `issue_left` > 0 after accounting for the current read,
  - `fifo_count + outstanding - pop_now < FIFO_DEPTH`.
  
  The FIFO must never overflow.
- **FIFO write:** each entry is written the cycle data returns. It stores the result field plus a last tag. The tag is set when the entry is the `num_words`-th word.
- **FIFO pop:** an entry is popped on an output transfer. A simultaneous push and pop in the same cycle leaves `fifo_count` unchanged.
- **Completion:** a transfer of the entry with `out_last=1` moves the state to FINISH on the next edge.
- `start` is ignored while `busy`.
- **Reset (including mid-drain):**
  - next cycle is IDLE,
  - FIFO and counters are cleared,
  - in-flight BRAM data is discarded,
  - outputs take their reset values.
- **Reset values:** `busy=0`, `done=0`, `bram_re=0`, `bram_addr=0`, `out_valid=0`, `out_data=0`, `out_last=0`.

## Timing
- Start is sampled in cycle 0.
- Cycle 1: `bram_re=1`, `bram_addr=start_addr`, `busy=1`.
- Cycle 2: `bram_data` is valid for the first address. It is written to the FIFO at the end of cycle 2.
- Cycle 3: `out_valid=1` with the first result. This gives a latency of 3 cycles from start to first valid.
- With `out_ready` held at 1, word k (0-based) transfers in cycle 3+k. For `num_words=N`, `out_last` is high in cycle N+2, `done` is high in cycle N+3, and IDLE is entered in cycle N+4.
- When `out_ready=0`, issue stalls once the FIFO plus outstanding reads reach `FIFO_DEPTH`. No word is lost or duplicated.
- `num_words=0`: `done` is high in cycle 1, with no `bram_re` and no `out_valid`.
- A start that coincides with `reset` is ignored.

## Test plan
- **Basic drain:** `start_addr=0`, `num_words=4`, BRAM[i] = {9'(i+1), 16'b0}, `out_ready=1`.
  - Expect `out_data` = 1, 2, 3, 4 in cycles 3–6.
  - Expect `out_last` in cycle 6 only and `done` in cycle 7.
- **Wrap-around:** `start_addr=510`, `num_words=4`.
  - Expect reads at addresses 510, 511, 0, 1, with data in that order.
- **Back-pressure:** `num_words=8`, `out_ready` toggles 1,0,0,1,… randomly.
  - Expect `fifo_count` to never exceed 4 and `bram_re` to deassert while the FIFO is full.
  - Expect all 8 words to arrive in order with no duplicates and `out_last` on the 8th.
- **Zero length:** `num_words=0`.
  - Expect `done` in cycle 1 and no `bram_re` or `out_valid` ever.
- **Reset mid-drain:** `num_words=16`, assert `reset` in cycle 6.
  - Expect all outputs at reset values in cycle 7, no further `bram_re`, and no `done`.
  - A new start then drains correctly from its new `start_addr`.
- **Start while busy:** pulse `start` again with a different `start_addr` during RUN.
  - Expect it to be ignored and the original drain to complete unchanged.
